// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch front end: default widths/sizes and the
// icache index/tag slicing helpers.
package fetch_unit_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int unsigned DefAddrW        = 32;
  localparam int unsigned DefInstW        = 32;
  localparam int unsigned DefQueueDepth   = 8;
  localparam int unsigned DefCacheEntries = 256;

  // Word-aligned PCs: index starts at bit 2, tag sits above the index.
  function automatic logic [63:0] cache_index(input logic [63:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] cache_tag(input logic [63:0] pc, input int unsigned idx_w);
    return pc >> (idx_w + 32'd2);
  endfunction

endpackage

// File: rtl/fetch_icache.sv
// Direct-mapped instruction cache, one instruction per line: combinational
// lookup, single write port and a bulk invalidate that beats a same-cycle write.
module fetch_icache
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned INST_W  = DefInstW,
  parameter int unsigned ENTRIES = DefCacheEntries
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rdy_i,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              hit_o,
  output logic [INST_W-1:0] hit_inst_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [INST_W-1:0] wr_inst_i,
  input  logic              inv_i
);

  localparam int unsigned IdxW = $clog2(ENTRIES);
  localparam int unsigned TagW = ADDR_W - IdxW - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TagW-1:0]    tag_q  [ENTRIES];
  logic [TagW-1:0]    tag_d  [ENTRIES];
  logic [INST_W-1:0]  data_q [ENTRIES];
  logic [INST_W-1:0]  data_d [ENTRIES];

  logic [IdxW-1:0] rd_idx, wr_idx;
  logic [TagW-1:0] rd_tag, wr_tag;

  assign rd_idx = IdxW'(cache_index(64'(lookup_addr_i), IdxW));
  assign rd_tag = TagW'(cache_tag(64'(lookup_addr_i), IdxW));
  assign wr_idx = IdxW'(cache_index(64'(wr_addr_i), IdxW));
  assign wr_tag = TagW'(cache_tag(64'(wr_addr_i), IdxW));

  assign hit_o      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign hit_inst_o = data_q[rd_idx];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en_i) begin
      valid_d[wr_idx] = TRUE;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_inst_i;
    end
    if (inv_i) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (rdy_i) begin
      valid_q <= valid_d;
    end
  end

  // Tag/data need no reset: a line is only read through its valid bit.
  always_ff @(posedge clk_i) begin
    if (rst_ni && rdy_i) begin
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC queue, icache/memory fill, in-order issue.
// Define FETCH_ICACHE_EN to build with the icache; otherwise every entry fills from memory.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W        = DefAddrW,
  parameter int unsigned INST_W        = DefInstW,
  parameter int unsigned QUEUE_DEPTH   = DefQueueDepth,
  parameter int unsigned CACHE_ENTRIES = DefCacheEntries
) (
  input  logic                           in_clk,
  input  logic                           in_rst_n,
  input  logic                           in_rdy,
  input  logic                           in_stall,
  input  logic                           in_flush,
  input  logic                           in_icache_inv,
  input  logic                           in_pc_valid,
  input  logic [ADDR_W-1:0]              in_pc,
  input  logic                           in_pred,
  output logic                           out_full,
  output logic [$clog2(QUEUE_DEPTH):0]   out_count,
  output logic                           out_last_valid,
  output logic [INST_W-1:0]              out_last_inst,
  output logic                           out_dec_valid,
  output logic [INST_W-1:0]              out_dec_inst,
  output logic [ADDR_W-1:0]              out_dec_pc,
  output logic                           out_dec_pred,
  output logic                           out_mem_req,
  output logic [ADDR_W-1:0]              out_mem_addr,
  input  logic                           in_mem_ready,
  input  logic                           in_mem_valid,
  input  logic [INST_W-1:0]              in_mem_inst
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [PtrW:0] PtrOne = 1;

  // Pointers carry a wrap bit so next==tail is unambiguous with a full queue.
  logic [PtrW:0]            head_q, head_d, next_q, next_d, tail_q, tail_d;
  logic [CntW-1:0]          count_q, count_d;
  logic [ADDR_W-1:0]        pc_q   [QUEUE_DEPTH];
  logic [ADDR_W-1:0]        pc_d   [QUEUE_DEPTH];
  logic [INST_W-1:0]        inst_q [QUEUE_DEPTH];
  logic [INST_W-1:0]        inst_d [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0]   pred_q, pred_d;
  logic                     pending_q, pending_d, drop_q, drop_d;
  logic [ADDR_W-1:0]        miss_addr_q, miss_addr_d;
  logic                     mem_req_q, mem_req_d;
  logic                     last_valid_q, last_valid_d;
  logic [INST_W-1:0]        last_inst_q, last_inst_d;
  logic                     dec_valid_q, dec_valid_d, dec_pred_q, dec_pred_d;
  logic [INST_W-1:0]        dec_inst_q, dec_inst_d;
  logic [ADDR_W-1:0]        dec_pc_q, dec_pc_d;

  logic              full, push, pop, resp, fill_req, hit;
  logic [INST_W-1:0] hit_inst;

`ifdef FETCH_ICACHE_EN
  fetch_icache #(
    .ADDR_W  (ADDR_W),
    .INST_W  (INST_W),
    .ENTRIES (CACHE_ENTRIES)
  ) u_icache (
    .clk_i         (in_clk),
    .rst_ni        (in_rst_n),
    .rdy_i         (in_rdy),
    .lookup_addr_i (pc_q[next_q[PtrW-1:0]]),
    .hit_o         (hit),
    .hit_inst_o    (hit_inst),
    .wr_en_i       (resp),
    .wr_addr_i     (miss_addr_q),
    .wr_inst_i     (in_mem_inst),
    .inv_i         (in_icache_inv)
  );
`else
  logic unused_cfg;
  assign unused_cfg = in_icache_inv ^ CACHE_ENTRIES[0];
  assign hit        = FALSE;
  assign hit_inst   = '0;
`endif

  assign full     = (count_q == CntW'(QUEUE_DEPTH));
  assign push     = in_pc_valid && !full;
  assign pop      = !in_stall && (head_q != next_q);
  assign resp     = in_mem_valid && pending_q;
  assign fill_req = (next_q != tail_q) && !pending_q;

  always_comb begin
    head_d       = head_q;
    next_d       = next_q;
    tail_d       = tail_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    pred_d       = pred_q;
    pending_d    = pending_q;
    drop_d       = drop_q;
    miss_addr_d  = miss_addr_q;
    mem_req_d    = FALSE;
    last_valid_d = FALSE;
    last_inst_d  = last_inst_q;
    dec_valid_d  = FALSE;
    dec_inst_d   = dec_inst_q;
    dec_pc_d     = dec_pc_q;
    dec_pred_d   = dec_pred_q;

    if (push) begin
      pc_d[tail_q[PtrW-1:0]]   = in_pc;
      pred_d[tail_q[PtrW-1:0]] = in_pred;
      tail_d                   = tail_q + PtrOne;
    end

    if (resp) begin
      pending_d = FALSE;
      drop_d    = FALSE;
      if (!drop_q) begin
        inst_d[next_q[PtrW-1:0]] = in_mem_inst;
        last_valid_d             = TRUE;
        last_inst_d              = in_mem_inst;
        next_d                   = next_q + PtrOne;
      end
    end else if (fill_req) begin
      if (hit) begin
        inst_d[next_q[PtrW-1:0]] = hit_inst;
        last_valid_d             = TRUE;
        last_inst_d              = hit_inst;
        next_d                   = next_q + PtrOne;
      end else if (in_mem_ready) begin
        mem_req_d   = TRUE;
        miss_addr_d = pc_q[next_q[PtrW-1:0]];
        pending_d   = TRUE;
      end
    end

    if (pop) begin
      dec_valid_d = TRUE;
      dec_inst_d  = inst_q[head_q[PtrW-1:0]];
      dec_pc_d    = pc_q[head_q[PtrW-1:0]];
      dec_pred_d  = pred_q[head_q[PtrW-1:0]];
      head_d      = head_q + PtrOne;
    end

    count_d = count_q + CntW'(push) - CntW'(pop);

    // A miss still in flight at flush time must not fill the emptied queue.
    if (in_flush) begin
      head_d       = '0;
      next_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      dec_valid_d  = FALSE;
      last_valid_d = FALSE;
      mem_req_d    = FALSE;
      pending_d    = pending_q && !resp;
      drop_d       = pending_q && !resp;
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      head_q       <= '0;
      next_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      pending_q    <= FALSE;
      drop_q       <= FALSE;
      miss_addr_q  <= '0;
      mem_req_q    <= FALSE;
      last_valid_q <= FALSE;
      last_inst_q  <= '0;
      dec_valid_q  <= FALSE;
      dec_inst_q   <= '0;
      dec_pc_q     <= '0;
      dec_pred_q   <= FALSE;
    end else if (in_rdy) begin
      head_q       <= head_d;
      next_q       <= next_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      pending_q    <= pending_d;
      drop_q       <= drop_d;
      miss_addr_q  <= miss_addr_d;
      mem_req_q    <= mem_req_d;
      last_valid_q <= last_valid_d;
      last_inst_q  <= last_inst_d;
      dec_valid_q  <= dec_valid_d;
      dec_inst_q   <= dec_inst_d;
      dec_pc_q     <= dec_pc_d;
      dec_pred_q   <= dec_pred_d;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst_n && in_rdy) begin
      pc_q   <= pc_d;
      inst_q <= inst_d;
      pred_q <= pred_d;
    end
  end

  assign out_full       = full;
  assign out_count      = count_q;
  assign out_last_valid = last_valid_q;
  assign out_last_inst  = last_inst_q;
  assign out_dec_valid  = dec_valid_q;
  assign out_dec_inst   = dec_inst_q;
  assign out_dec_pc     = dec_pc_q;
  assign out_dec_pred   = dec_pred_q;
  assign out_mem_req    = mem_req_q;
  assign out_mem_addr   = miss_addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; expectations follow FETCH_ICACHE_EN.
module tb_fetch_unit;

`ifdef FETCH_ICACHE_EN
  localparam bit CacheEn = 1'b1;
`else
  localparam bit CacheEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n, rdy, stall, flush, icache_inv;
  logic        pc_valid, pred;
  logic [31:0] pc;
  logic        full;
  logic [3:0]  count;
  logic        last_valid, dec_valid, dec_pred, mem_req;
  logic [31:0] last_inst, dec_inst, dec_pc, mem_addr;
  logic        mem_ready, mem_valid;
  logic [31:0] mem_inst;

  int errors = 0;
  int checks = 0;

  fetch_unit #(
    .ADDR_W        (32),
    .INST_W        (32),
    .QUEUE_DEPTH   (8),
    .CACHE_ENTRIES (256)
  ) dut (
    .in_clk         (clk),
    .in_rst_n       (rst_n),
    .in_rdy         (rdy),
    .in_stall       (stall),
    .in_flush       (flush),
    .in_icache_inv  (icache_inv),
    .in_pc_valid    (pc_valid),
    .in_pc          (pc),
    .in_pred        (pred),
    .out_full       (full),
    .out_count      (count),
    .out_last_valid (last_valid),
    .out_last_inst  (last_inst),
    .out_dec_valid  (dec_valid),
    .out_dec_inst   (dec_inst),
    .out_dec_pc     (dec_pc),
    .out_dec_pred   (dec_pred),
    .out_mem_req    (mem_req),
    .out_mem_addr   (mem_addr),
    .in_mem_ready   (mem_ready),
    .in_mem_valid   (mem_valid),
    .in_mem_inst    (mem_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic push_one(input logic [31:0] a, input logic p);
    pc_valid = 1'b1; pc = a; pred = p;
    tick();
    pc_valid = 1'b0; pred = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; stall = 1'b0; flush = 1'b0; icache_inv = 1'b0;
    pc_valid = 1'b0; pc = '0; pred = 1'b0; mem_ready = 1'b1; mem_valid = 1'b0; mem_inst = '0;
    tick(); tick();
    rst_n = 1'b1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if ({dec_valid, last_valid, mem_req} !== 3'b000) begin
      errors++; $display("FAIL reset_valids: got %b want 000", {dec_valid, last_valid, mem_req}); end
    checks++; if (mem_addr !== 32'h0 || dec_pc !== 32'h0 || dec_inst !== 32'h0) begin
      errors++; $display("FAIL reset_data: got addr %h pc %h inst %h want 0", mem_addr, dec_pc, dec_inst); end
  endtask

  task automatic test_miss();
    push_one(32'h1000, 1'b1);
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL miss_count: got %0d want 1", count); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1000) begin
      errors++; $display("FAIL miss_req: got %b/%h want 1/00001000", mem_req, mem_addr); end
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL miss_req_pulse: got %b want 0", mem_req); end
    mem_valid = 1'b1; mem_inst = 32'h00500093;
    tick();
    mem_valid = 1'b0;
    checks++; if (last_valid !== 1'b1 || last_inst !== 32'h00500093) begin
      errors++; $display("FAIL miss_last: got %b/%h want 1/00500093", last_valid, last_inst); end
    tick();
    checks++; if (dec_valid !== 1'b1 || dec_inst !== 32'h00500093 || dec_pc !== 32'h1000
                  || dec_pred !== 1'b1) begin
      errors++; $display("FAIL miss_issue: got %b %h %h %b want 1 00500093 00001000 1",
                         dec_valid, dec_inst, dec_pc, dec_pred); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL miss_count_after: got %0d want 0", count); end
    tick();
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL miss_issue_pulse: got %b want 0", dec_valid); end
  endtask

  task automatic test_hit();
    flush = 1'b1; tick(); flush = 1'b0;
    push_one(32'h1000, 1'b0);
    tick();
    checks++; if (mem_req !== !CacheEn) begin
      errors++; $display("FAIL hit_req: got %b want %b", mem_req, !CacheEn); end
    checks++; if (last_valid !== CacheEn) begin
      errors++; $display("FAIL hit_last: got %b want %b", last_valid, CacheEn); end
    if (!CacheEn) begin
      mem_valid = 1'b1; mem_inst = 32'h00500093; tick(); mem_valid = 1'b0;
    end
    tick();
    checks++; if (dec_valid !== 1'b1 || dec_inst !== 32'h00500093 || dec_pc !== 32'h1000) begin
      errors++; $display("FAIL hit_issue: got %b %h %h want 1 00500093 00001000",
                         dec_valid, dec_inst, dec_pc); end
    tick();
  endtask

  task automatic test_full();
    stall = 1'b1;
    fork
      begin
        for (int i = 0; i < 9; i++) begin
          pc_valid = 1'b1; pc = 32'h100 + 32'(4 * i);
          if (i == 8) begin
            checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", full); end
          end
          tick();
        end
        pc_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 8; i++) begin
          bit ok;
          wait_req(ok);
          checks++; if (!ok || mem_addr !== 32'h100 + 32'(4 * i)) begin
            errors++; $display("FAIL full_req%0d: got %b/%h want 1/%h", i, ok, mem_addr,
                               32'h100 + 32'(4 * i)); end
          mem_valid = 1'b1; mem_inst = 32'h113 + 32'(4 * i);
          tick();
          mem_valid = 1'b0;
        end
      end
    join
    checks++; if (count !== 4'd8 || full !== 1'b1) begin
      errors++; $display("FAIL full_count: got %0d/%b want 8/1", count, full); end
    stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h100 + 32'(4 * i)
                    || dec_inst !== 32'h113 + 32'(4 * i)) begin
        errors++; $display("FAIL full_issue%0d: got %b %h %h want 1 %h %h", i, dec_valid, dec_pc,
                           dec_inst, 32'h100 + 32'(4 * i), 32'h113 + 32'(4 * i)); end
    end
    tick();
    checks++; if (dec_valid !== 1'b0 || count !== 4'd0) begin
      errors++; $display("FAIL full_drain: got %b/%0d want 0/0", dec_valid, count); end
  endtask

  task automatic test_flush_pending();
    push_one(32'h2000, 1'b0);
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h2000) begin
      errors++; $display("FAIL flush_req: got %b/%h want 1/00002000", mem_req, mem_addr); end
    flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
    push_one(32'h3004, 1'b0);
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL flush_no_req: got %b want 0", mem_req); end
    mem_valid = 1'b1; mem_inst = 32'h00a00113;
    tick();
    mem_valid = 1'b0;
    checks++; if (last_valid !== 1'b0 || dec_valid !== 1'b0) begin
      errors++; $display("FAIL flush_drop: got last %b dec %b want 0 0", last_valid, dec_valid); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h3004) begin
      errors++; $display("FAIL flush_next_req: got %b/%h want 1/00003004", mem_req, mem_addr); end
    mem_valid = 1'b1; mem_inst = 32'h00b00213;
    tick();
    mem_valid = 1'b0;
    tick();
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h3004 || dec_inst !== 32'h00b00213) begin
      errors++; $display("FAIL flush_issue: got %b %h %h want 1 00003004 00b00213",
                         dec_valid, dec_pc, dec_inst); end
    push_one(32'h2000, 1'b0);
    tick();
    checks++; if (last_valid !== CacheEn || mem_req !== !CacheEn) begin
      errors++; $display("FAIL flush_relookup: got last %b req %b want %b %b",
                         last_valid, mem_req, CacheEn, !CacheEn); end
    if (!CacheEn) begin
      mem_valid = 1'b1; mem_inst = 32'h00a00113; tick(); mem_valid = 1'b0;
    end
    tick();
    checks++; if (dec_valid !== 1'b1 || dec_inst !== 32'h00a00113 || dec_pc !== 32'h2000) begin
      errors++; $display("FAIL flush_hit_issue: got %b %h %h want 1 00a00113 00002000",
                         dec_valid, dec_inst, dec_pc); end
    tick();
  endtask

  task automatic test_inv();
    push_one(32'h1000, 1'b0);
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL inv_req: got %b want 1", mem_req); end
    mem_valid = 1'b1; mem_inst = 32'h00c00193; icache_inv = 1'b1;
    tick();
    mem_valid = 1'b0; icache_inv = 1'b0;
    checks++; if (last_valid !== 1'b1 || last_inst !== 32'h00c00193) begin
      errors++; $display("FAIL inv_fill: got %b/%h want 1/00c00193", last_valid, last_inst); end
    tick();
    checks++; if (dec_valid !== 1'b1 || dec_inst !== 32'h00c00193) begin
      errors++; $display("FAIL inv_issue: got %b/%h want 1/00c00193", dec_valid, dec_inst); end
    push_one(32'h1000, 1'b0);
    tick();
    checks++; if (mem_req !== 1'b1 || last_valid !== 1'b0) begin
      errors++; $display("FAIL inv_remiss: got req %b last %b want 1 0", mem_req, last_valid); end
    mem_valid = 1'b1; mem_inst = 32'h00c00193; tick(); mem_valid = 1'b0;
    tick();
  endtask

  task automatic test_rdy_freeze();
    push_one(32'h4008, 1'b1);
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4008) begin
      errors++; $display("FAIL rdy_req: got %b/%h want 1/00004008", mem_req, mem_addr); end
    rdy = 1'b0; pc_valid = 1'b1; pc = 32'h5000; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (mem_req !== 1'b1 || count !== 4'd1 || mem_addr !== 32'h4008) begin
        errors++; $display("FAIL rdy_frozen%0d: got req %b count %0d addr %h want 1 1 00004008",
                           i, mem_req, count, mem_addr); end
    end
    rdy = 1'b1; pc_valid = 1'b0; flush = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b0 || count !== 4'd1) begin
      errors++; $display("FAIL rdy_resume: got req %b count %0d want 0 1", mem_req, count); end
    mem_valid = 1'b1; mem_inst = 32'h00d00293; tick(); mem_valid = 1'b0;
    tick();
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h4008 || dec_pred !== 1'b1
                  || dec_inst !== 32'h00d00293) begin
      errors++; $display("FAIL rdy_issue: got %b %h %b %h want 1 00004008 1 00d00293",
                         dec_valid, dec_pc, dec_pred, dec_inst); end
    tick();
  endtask

  task automatic test_reset_mid_miss();
    push_one(32'h6000, 1'b0);
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_miss_req: got %b want 1", mem_req); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    mem_valid = 1'b1; mem_inst = 32'h00e00313;
    tick();
    mem_valid = 1'b0;
    checks++; if (last_valid !== 1'b0 || count !== 4'd0) begin
      errors++; $display("FAIL rst_late_resp: got last %b count %0d want 0 0", last_valid, count); end
    push_one(32'h6000, 1'b0);
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h6000) begin
      errors++; $display("FAIL rst_new_req: got %b/%h want 1/00006000", mem_req, mem_addr); end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_full();
    test_flush_pending();
    test_inv();
    test_rdy_freeze();
    test_reset_mid_miss();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end: buffers PCs from the PC controller in a circular queue, fills each entry from a direct-mapped icache or from the memory dispatcher, and issues instructions in order to the decoder. It sits between the PC controller, the dispatcher's instruction port and the decoder. It generalises queue depth, cache size and widths, and adds tracked outstanding misses across flushes and a whole-cache invalidate.

## Interface
- ADDR_W, 32, PC width
- INST_W, 32, instruction width
- QUEUE_DEPTH, 8, queue entries; power of 2, ≥2
- CACHE_ENTRIES, 256, icache lines, one instruction each; power of 2
- in_clk  in  1  clock, all state on rising edge
- in_rst_n  in  1  reset, synchronous, active-low
- in_rdy  in  1  global enable; low = all state and outputs hold
- in_stall  in  1  decoder backpressure
- in_flush  in  1  clear queue (cache kept)
- in_icache_inv  in  1  invalidate every cache line
- in_pc_valid / in_pc / in_pred  in  1/ADDR_W/1  push PC with its own prediction bit
- out_full  out  1  combinational, count == QUEUE_DEPTH
- out_count  out  log2(QUEUE_DEPTH)+1  occupied entries
- out_last_valid / out_last_inst  out  1/INST_W  pulse per filled entry, to PC controller predecode
- out_dec_valid / out_dec_inst / out_dec_pc / out_dec_pred  out  1/INST_W/ADDR_W/1  issue to decoder
- out_mem_req / out_mem_addr  out  1/ADDR_W  one-cycle request pulse plus address
- in_mem_ready  in  1  dispatcher can accept a request
- in_mem_valid / in_mem_inst  in  1/INST_W  response

## Operation
- Pointers head (issue), next (fill), tail (push); explicit count. Cache index = pc[IDX_W+1:2], tag = pc[ADDR_W-1:IDX_W+2].
- Push: in_pc_valid && !out_full writes pc/pred at tail, tail++. Push while full is dropped.
- Fill, when next≠tail and no miss outstanding: hit → write inst, out_last_valid pulse, next++; miss && in_mem_ready → out_mem_req pulse, capture address, set pending.
- Response (in_mem_valid && pending): write cache line at captured address; unless drop set, write entry at next, pulse out_last_valid, next++; clear pending and drop.
- Issue: if !in_stall and head≠next, register entry to out_dec_*, head++; else out_dec_valid←0.
- count ← count + push − pop, same cycle both allowed, including when full (out_full is from current count, so push is refused that cycle).
- Flush: head=next=tail=0, count 0, out_dec_valid/out_last_valid/out_mem_req ← 0. If pending, set drop; no new request until the response returns. Flush beats push/issue in the same cycle.
- in_icache_inv clears all valid bits; it beats a same-cycle response line write.
- Pointers wrap modulo QUEUE_DEPTH.

## Timing
- Reset: every output 0, pointers/count 0, pending/drop 0, cache invalid.
- Push at edge E0 → hit fill E1 → out_dec_valid high after E2 (2-cycle hit latency).
- Miss: out_mem_req high cycle after E1 for exactly one cycle; response at edge Ek fills, issue at Ek+1.
- One outstanding miss maximum; out_mem_req never asserted while pending.
- Reset mid-miss: pending cleared; late in_mem_valid without pending is ignored.

## Configuration
- FETCH_ICACHE_EN defined: icache as above.
- Undefined: no cache storage; every entry is a miss through memory; in_icache_inv ignored; responses still fill the queue.

## Structure
- Shared defs header: TRUE/FALSE, default widths, QUEUE_DEPTH/CACHE_ENTRIES defaults, index/tag slice helpers.
- Sub-module fetch_icache: direct-mapped valid/tag/data arrays, combinational lookup, write port, bulk invalidate.

## Test plan
- Reset, push 0x1000 (miss), response 0x00500093 two cycles later → out_dec_inst=0x00500093, pc=0x1000, cache line filled.
- Push 0x1000 again after flush → hit, out_mem_req stays 0, out_dec_valid 2 cycles after push.
- Push 8 PCs with in_stall=1 → out_full=1, out_count=8, 9th push dropped; release stall → 8 issues in order, wrap correct.
- Flush while miss for 0x2000 pending, then response → no queue entry, no out_dec_valid, next lookup of 0x2000 hits.
- in_icache_inv same cycle as response → queue filled, line invalid, later 0x1000 misses.
- in_rdy=0 for 3 cycles mid-stream → all outputs and counts frozen, resume identical.
